// File: rtl/serial_tx_framer.sv
// Serial transmit framer: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Define SERIAL_TX_PARITY_EN to include the parity bit (sense selected by PARITY_ODD).
module serial_tx_framer #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              inclk,
  input  logic              resetn,
  input  logic              sclk,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int                 CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W);
  localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [1:0]        stopcnt_q, stopcnt_d;
  logic              txd_d;
  logic              sync1_q, sync_q, hist_q;
  logic              bit_tick;
  logic              transfer;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // sclk is asynchronous to inclk: two flops to resolve metastability, a third for edge history.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge inclk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sclk;
      sync_q  <= sync1_q;
      hist_q  <= sync_q;
    end
  end

  assign bit_tick = sync_q & ~hist_q;
  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign transfer = tx_valid & tx_ready;

  always_ff @(posedge inclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= '0;
      txd       <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      txd       <= txd_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    txd_d     = txd;
    done      = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        // A tick coinciding with the transfer is not seen: ARM only acts from the next cycle.
        if (transfer) begin
          shift_d  = tx_data;
          bitcnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          par_d    = (^tx_data) ^ 1'(PARITY_ODD);
`endif
          state_d  = ARM;
        end
      end
      ARM: begin
        if (bit_tick) begin
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_tick) begin
          txd_d    = shift_q[0];
          shift_d  = shift_q >> 1;
          bitcnt_d = CNT_W'(1);
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bitcnt_q < BIT_LAST) begin
            txd_d    = shift_q[0];
            shift_d  = shift_q >> 1;
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end else begin
`ifdef SERIAL_TX_PARITY_EN
            txd_d     = par_q;
            state_d   = PARITY;
`else
            txd_d     = 1'b1;
            stopcnt_d = 2'd1;
            state_d   = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          txd_d     = 1'b1;
          stopcnt_d = 2'd1;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (stopcnt_q < STOP_LAST) begin
            stopcnt_d = stopcnt_q + 2'd1;
          end else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Self-checking bench for serial_tx_framer: a divider model drives sclk and a scoreboard of
// expected line bits is compared cycle by cycle against txd, busy and done.
module tb_serial_tx_framer;

  localparam int DATA_W    = 8;
  localparam int STOP_BITS = 1;
  localparam int MAXCOUNT  = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 1 + DATA_W + PAR + STOP_BITS;

  logic              inclk    = 1'b0;
  logic              resetn   = 1'b1;
  logic              sclk     = 1'b0;
  logic              ena      = 1'b1;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data  = '0;
  logic              tx_ready, txd, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_tx_framer #(.DATA_W(DATA_W), .STOP_BITS(STOP_BITS), .PARITY_ODD(0)) dut (
    .inclk(inclk), .resetn(resetn), .sclk(sclk), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .busy(busy), .done(done)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic tx_ready_o, txd_o, busy_o, done_o;
  serial_tx_framer #(.DATA_W(DATA_W), .STOP_BITS(STOP_BITS), .PARITY_ODD(1)) dut_odd (
    .inclk(inclk), .resetn(resetn), .sclk(sclk), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready_o), .txd(txd_o), .busy(busy_o), .done(done_o)
  );
`endif

  always #5 inclk = ~inclk;

  // Divider model: sclk toggles every MAXCOUNT+1 cycles, held low while disabled.
  // rd1..rd3 delay the rising-edge count to line up with the framer's synchroniser.
  int div_cnt = 0, rises = 0, rd1 = 0, rd2 = 0, rd3 = 0, rd3_prev = 0;
  always @(posedge inclk) begin
    if (!ena) begin
      div_cnt <= 0;
      sclk    <= 1'b0;
    end else if (div_cnt == MAXCOUNT) begin
      div_cnt <= 0;
      sclk    <= ~sclk;
      if (!sclk) rises <= rises + 1;
    end else begin
      div_cnt <= div_cnt + 1;
    end
    rd1 <= rises;
    rd2 <= rd1;
    rd3 <= rd2;
  end

  function automatic logic [31:0] frame_bits(input logic [DATA_W-1:0] d, input logic odd);
    logic [31:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) b[1+i] = d[i];
    if (PAR == 1) b[1+DATA_W] = (^d) ^ odd;
    return b;
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] cur      = '1;
  bit          in_frame = 1'b0;
  int          rc_start = 0, cur_idx = 0, last_end = 0, last_gap = 0, starts = 0, done_cnt = 0;

  // Scoreboard monitor: line bit index = sclk rising edges since the start bit began.
  always @(negedge inclk) begin
    if (!resetn) begin
      in_frame = 1'b0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (!in_frame) begin
        n_checks++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_outside_frame: got %b want 0", done);
        end
        if (txd === 1'b0) begin
          n_checks++;
          if (rd3 == rd3_prev) begin
            n_fail++;
            $display("FAIL start_off_tick: start bit began without an sclk edge (count %0d)", rd3);
          end
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame: got start bit, want idle line");
          end else begin
            cur      = exp_q.pop_front();
            in_frame = 1'b1;
            rc_start = rd3;
            last_gap = rd3 - last_end;
            starts++;
          end
        end
      end
      if (in_frame) begin
        cur_idx = rd3 - rc_start;
        if (cur_idx >= NB) begin
          in_frame = 1'b0;
          last_end = rd3;
        end else begin
          n_checks += 4;
          if (txd !== cur[cur_idx]) begin
            n_fail++;
            $display("FAIL txd_bit%0d: got %b want %b", cur_idx, txd, cur[cur_idx]);
          end
          if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_frame: got %b want 1 (bit %0d)", busy, cur_idx);
          end
          if (tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_frame: got %b want 0 (bit %0d)", tx_ready, cur_idx);
          end
          if (done !== ((rd2 - rc_start) == NB)) begin
            n_fail++;
            $display("FAIL done_timing: got %b want %b (bit %0d)", done, (rd2 - rc_start) == NB, cur_idx);
          end
`ifdef SERIAL_TX_PARITY_EN
          n_checks++;
          if (txd_o !== (cur[cur_idx] ^ (cur_idx == 1 + DATA_W))) begin
            n_fail++;
            $display("FAIL txd_odd_bit%0d: got %b want %b", cur_idx, txd_o,
                     cur[cur_idx] ^ (cur_idx == 1 + DATA_W));
          end
`endif
        end
      end
    end
    rd3_prev = rd3;
  end

  task automatic send(input logic [DATA_W-1:0] d);
    int c = 0;
    @(negedge inclk);
    while (tx_ready !== 1'b1 && c < 3000) begin
      @(negedge inclk);
      c++;
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready_timeout: tx_ready=%b want 1", tx_ready);
    end else begin
      tx_data  = d;
      tx_valid = 1'b1;
      exp_q.push_back(frame_bits(d, 1'b0));
      @(posedge inclk);
      #1;
      tx_valid = 1'b0;
      tx_data  = ~d;
    end
  endtask

  task automatic wait_frames(input string tag);
    int c = 0;
    while ((exp_q.size() != 0 || in_frame) && c < 5000) begin
      @(negedge inclk);
      c++;
    end
    n_checks++;
    if (exp_q.size() != 0 || in_frame) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d frames pending, want 0", tag, exp_q.size());
    end
  endtask

  task automatic wait_bit(input int idx, input string tag);
    int c = 0;
    while (!(in_frame && cur_idx == idx) && c < 3000) begin
      @(negedge inclk);
      c++;
    end
    n_checks++;
    if (!(in_frame && cur_idx == idx)) begin
      n_fail++;
      $display("FAIL %s_reach_bit: at bit %0d, want bit %0d", tag, cur_idx, idx);
    end
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    n_checks += 4;
    if (txd !== 1'b1)      begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    repeat (3) @(negedge inclk);
    resetn = 1'b1;
    repeat (30) @(negedge inclk);
  endtask

  task automatic test_single_frame();
    int d0 = done_cnt;
    send(8'hA5);
    wait_frames("single");
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL single_done_count: got %0d pulses want 1", done_cnt - d0);
    end
  endtask

  task automatic test_parity();
    int d0 = done_cnt;
    send(8'h07);
    wait_frames("parity07");
    send(8'h80);
    wait_frames("parity80");
    n_checks++;
    if (done_cnt - d0 != 2) begin
      n_fail++;
      $display("FAIL parity_done_count: got %0d pulses want 2", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int c = 0, ready_cnt = 0, d0 = done_cnt;
    @(negedge inclk);
    while (tx_ready !== 1'b1 && c < 3000) begin
      @(negedge inclk);
      c++;
    end
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    exp_q.push_back(frame_bits(8'h55, 1'b0));
    @(posedge inclk);
    #1 tx_data = 8'hFF;
    c = 0;
    while (c < 3000) begin
      @(negedge inclk);
      c++;
      if (tx_ready === 1'b1) begin
        ready_cnt++;
        break;
      end
    end
    exp_q.push_back(frame_bits(8'hFF, 1'b0));
    @(posedge inclk);
    #1 tx_valid = 1'b0;
    repeat (20) begin
      @(negedge inclk);
      if (tx_ready === 1'b1) ready_cnt++;
    end
    n_checks++;
    if (ready_cnt != 1) begin
      n_fail++;
      $display("FAIL b2b_ready_cycles: got %0d want 1", ready_cnt);
    end
    wait_frames("b2b");
    // Stop bit ends on one edge; the waiting frame starts on the next one.
    n_checks += 2;
    if (last_gap != 1) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d sclk edges want 1", last_gap);
    end
    if (done_cnt - d0 != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0);
    end
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] w = 8'hC3;
    int d0 = done_cnt;
    send(w);
    wait_bit(4, "stall");
    repeat (3) @(negedge inclk);
    ena = 1'b0;
    repeat (80) @(negedge inclk);
    n_checks += 4;
    if (txd !== w[3])        begin n_fail++; $display("FAIL stall_txd: got %b want %b", txd, w[3]); end
    if (busy !== 1'b1)       begin n_fail++; $display("FAIL stall_busy: got %b want 1", busy); end
    if (cur_idx != 4)        begin n_fail++; $display("FAIL stall_bit: got %0d want 4", cur_idx); end
    if (done_cnt != d0)      begin n_fail++; $display("FAIL stall_done: got %0d pulses want 0", done_cnt - d0); end
    ena = 1'b1;
    wait_frames("stall");
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL stall_resume_done: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_holdoff();
    int s0 = starts;
    send(8'h3C);
    repeat (15) @(negedge inclk);
    for (int i = 0; i < 40; i++) begin
      @(negedge inclk);
      n_checks++;
      if (tx_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL holdoff_ready: got %b want 0", tx_ready);
      end
      tx_valid = 1'b1;
      tx_data  = DATA_W'($urandom);
    end
    @(negedge inclk);
    tx_valid = 1'b0;
    wait_frames("holdoff");
    repeat (40) @(negedge inclk);
    n_checks++;
    if (starts - s0 != 1) begin
      n_fail++;
      $display("FAIL holdoff_frames: got %0d frames want 1", starts - s0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    send(8'h00);
    wait_bit(3, "midreset");
    n_checks++;
    if (txd !== 1'b0) begin n_fail++; $display("FAIL midreset_pre_txd: got %b want 0", txd); end
    @(posedge inclk);
    #2 resetn = 1'b0;
    #1;
    n_checks += 3;
    if (txd !== 1'b1)      begin n_fail++; $display("FAIL midreset_txd: got %b want 1", txd); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", tx_ready); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    exp_q.delete();
    repeat (2) @(negedge inclk);
    resetn = 1'b1;
    repeat (40) @(negedge inclk);
    d0 = done_cnt;
    send(8'h81);
    wait_frames("after_reset");
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL after_reset_done: got %0d want 1", done_cnt - d0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_stall();
    test_holdoff();
    test_reset_mid_frame();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d frames left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
